// File: rtl/fetch_pkg.sv
// Shared types for the bytecode fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_OP,
    LATCH_OP,
    DECODE,
    FETCH_ARG,
    LATCH_ARG,
    ISSUE
  } fetch_state_t;

  // No opcode carries more than two argument bytes; argc=3 is treated as 2.
  function automatic logic [1:0] clamp_argc(input logic [1:0] argc);
    return (argc == 2'd3) ? 2'd2 : argc;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Bytecode fetch sequencer: reads opcode plus 0..2 argument bytes from a
// one-cycle-latency byte memory and issues bundles on a valid/ready handshake.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_data,
  output logic [7:0]          opcode,
  input  logic [1:0]          argc,
  output logic [7:0]          arg1,
  output logic [7:0]          arg2,
  output logic [PC_WIDTH-1:0] ins_pc,
  output logic                ins_valid,
  input  logic                ins_ready,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] ins_pc_q;
  logic [1:0]          args_left;
  logic                arg_second;
  logic [1:0]          argc_c;

  assign argc_c    = clamp_argc(argc);
  assign mem_rd    = ((state == FETCH_OP) || (state == FETCH_ARG)) && !rst;
  assign mem_addr  = rst ? '0 : pc;
  assign ins_valid = (state == ISSUE) && !rst;
  assign ins_pc    = ins_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH_OP;
      pc         <= '0;
      ins_pc_q   <= '0;
      opcode     <= 8'h00;
      arg1       <= 8'h00;
      arg2       <= 8'h00;
      args_left  <= 2'd0;
      arg_second <= 1'b0;
    end else if (redirect) begin
      // Any read in flight is simply never latched; the partial bundle is lost.
      state      <= FETCH_OP;
      pc         <= redirect_pc;
      args_left  <= 2'd0;
      arg_second <= 1'b0;
    end else begin
      unique case (state)
        FETCH_OP: begin
          ins_pc_q <= pc;
          state    <= LATCH_OP;
        end
        LATCH_OP: begin
          opcode     <= mem_data;
          pc         <= pc + PC_WIDTH'(1);
          arg1       <= 8'h00;
          arg2       <= 8'h00;
          arg_second <= 1'b0;
          state      <= DECODE;
        end
        DECODE: begin
          args_left <= argc_c;
          state     <= (argc_c == 2'd0) ? ISSUE : FETCH_ARG;
        end
        FETCH_ARG: state <= LATCH_ARG;
        LATCH_ARG: begin
          if (arg_second) arg2 <= mem_data;
          else            arg1 <= mem_data;
          arg_second <= 1'b1;
          pc         <= pc + PC_WIDTH'(1);
          args_left  <= args_left - 2'd1;
          state      <= (args_left == 2'd1) ? ISSUE : FETCH_ARG;
        end
        ISSUE: if (ins_ready) state <= FETCH_OP;
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: directed timing/redirect/reset cases,
// a randomized program walk, and a PC_WIDTH=4 wrap-around instance.
module tb_instr_fetch;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [15:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst, ins_ready, redirect;
  logic [15:0] mem_addr, ins_pc, redirect_pc;
  logic        mem_rd, ins_valid;
  logic [7:0]  mem_data, opcode, arg1, arg2;
  logic [1:0]  argc;

  logic        rst4, ready4, redirect4;
  logic [3:0]  b_mem_addr, b_ins_pc, b_redirect_pc;
  logic        b_mem_rd, b_ins_valid;
  logic [7:0]  b_mem_data, b_opcode, b_arg1, b_arg2;
  logic [1:0]  b_argc;

  logic [7:0]  mem  [0:65535];
  logic [7:0]  mem4 [0:15];
  logic [1:0]  argc_tab [0:255];

  bundle_t exp_q[$];
  int n_chk = 0, n_fail = 0, hs_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .opcode(opcode), .argc(argc), .arg1(arg1), .arg2(arg2), .ins_pc(ins_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .redirect(redirect),
    .redirect_pc(redirect_pc));

  instr_fetch #(.PC_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_data(b_mem_data),
    .opcode(b_opcode), .argc(b_argc), .arg1(b_arg1), .arg2(b_arg2), .ins_pc(b_ins_pc),
    .ins_valid(b_ins_valid), .ins_ready(ready4), .redirect(redirect4),
    .redirect_pc(b_redirect_pc));

  // Synchronous memories; unread cycles return junk so stale data is caught.
  always @(posedge clk) begin
    mem_data   <= mem_rd   ? mem[mem_addr]    : 8'($urandom);
    b_mem_data <= b_mem_rd ? mem4[b_mem_addr] : 8'($urandom);
  end

  assign argc   = argc_tab[opcode];
  assign b_argc = argc_tab[b_opcode];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ins_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Reference: walk the byte stream by the ISA rules and queue the bundles.
  task automatic predict(input logic [15:0] start, input int count);
    logic [15:0] p;
    int k;
    bundle_t b;
    p = start;
    for (int i = 0; i < count; i++) begin
      b.op = mem[p];
      b.pc = p;
      k = (argc_tab[b.op] == 2'd3) ? 2 : int'(argc_tab[b.op]);
      b.a1 = (k >= 1) ? mem[16'(p + 16'd1)] : 8'h00;
      b.a2 = (k == 2) ? mem[16'(p + 16'd2)] : 8'h00;
      exp_q.push_back(b);
      p = 16'(p + 16'(1 + k));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ins_valid && ins_ready) begin
      bundle_t e;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got bundle op=%0h pc=%0h expected none", opcode, ins_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_opcode", 32'(opcode), 32'(e.op));
        check("sb_arg1",   32'(arg1),   32'(e.a1));
        check("sb_arg2",   32'(arg2),   32'(e.a2));
        check("sb_ins_pc", 32'(ins_pc), 32'(e.pc));
      end
    end
  end

  initial begin
    int n, hs0;
    rst = 1'b1; ins_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    rst4 = 1'b1; ready4 = 1'b1; redirect4 = 1'b0; b_redirect_pc = '0;
    for (int i = 0; i < 256; i++) argc_tab[i] = 2'($urandom_range(0, 3));
    argc_tab[8'h04] = 2'd0; argc_tab[8'h10] = 2'd1;
    argc_tab[8'h11] = 2'd2; argc_tab[8'hA7] = 2'd2;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
    mem[0] = 8'h04; mem[1] = 8'h11; mem[2] = 8'h01; mem[3] = 8'h2C;
    mem[4] = 8'h10; mem[5] = 8'h2A;
    mem[16'h10] = 8'hA7; mem[16'h11] = 8'h00; mem[16'h12] = 8'h30;
    mem[16'h40] = 8'h04; mem[16'h80] = 8'h10; mem[16'h81] = 8'h55;
    mem4[15] = 8'h10; mem4[0] = 8'h77; mem4[1] = 8'h04;

    repeat (3) tick();
    check("rst_valid", 32'(ins_valid), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_opcode", 32'(opcode), 0);
    check("rst_args", {arg1, arg2}, 0);
    check("rst_ins_pc", 32'(ins_pc), 0);

    // ICONST_1 then SIPUSH then BIPUSH, ready high.
    predict(16'h0000, 3);
    rst = 1'b0;
    #1;
    check("c0_mem_rd", 32'(mem_rd), 1);
    check("c0_mem_addr", 32'(mem_addr), 0);
    tick(); check("c1_valid", 32'(ins_valid), 0);
    tick(); check("c2_valid", 32'(ins_valid), 0);
    tick();
    check("argc0_valid_c3", 32'(ins_valid), 1);
    check("argc0_args", {arg1, arg2}, 0);
    tick();
    check("next_fetch_rd", 32'(mem_rd), 1);
    check("next_fetch_addr", 32'(mem_addr), 1);
    wait_valid(n);
    check("argc2_latency", n, 7);
    check("sipush_args", {arg1, arg2}, 32'h012C);
    tick();
    check("after_sipush_addr", 32'(mem_addr), 4);

    // BIPUSH stalled five cycles in ISSUE.
    ins_ready = 1'b0;
    hs0 = hs_cnt;
    wait_valid(n);
    check("argc1_latency", n, 5);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(ins_valid), 1);
      check("stall_bundle", {opcode, arg1, arg2}, 32'h102A00);
      check("stall_ins_pc", 32'(ins_pc), 4);
      check("stall_mem_rd", 32'(mem_rd), 0);
      if (i < 4) tick();
    end
    ins_ready = 1'b1;
    tick();
    check("stall_hs_once", hs_cnt - hs0, 1);
    check("after_stall_addr", 32'(mem_addr), 6);
    check("after_stall_rd", 32'(mem_rd), 1);

    // Redirect to GOTO, then redirect again during its first LATCH_ARG.
    redirect = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    check("redir_goto_addr", 32'(mem_addr), 32'h10);
    hs0 = hs_cnt;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("goto_no_valid", 32'(ins_valid), 0);
      if (i == 3) check("goto_arg_addr", 32'(mem_addr), 32'h11);
    end
    redirect = 1'b1; redirect_pc = 16'h0040;
    predict(16'h0040, 1);
    tick();
    redirect = 1'b0;
    check("redir_arg_rd", 32'(mem_rd), 1);
    check("redir_arg_addr", 32'(mem_addr), 32'h40);
    check("redir_arg_valid", 32'(ins_valid), 0);
    check("goto_dropped", hs_cnt - hs0, 0);

    // Redirect coincident with an accepted handshake.
    wait_valid(n);
    check("redir_ins_latency", n, 3);
    hs0 = hs_cnt;
    redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect = 1'b0;
    check("redir_hs_counted", hs_cnt - hs0, 1);
    check("redir_hs_addr", 32'(mem_addr), 32'h80);
    check("redir_hs_rd", 32'(mem_rd), 1);
    check("redir_hs_q_empty", exp_q.size(), 0);

    // Redirect while stalled drops the bundle.
    ins_ready = 1'b0;
    wait_valid(n);
    check("drop_latency", n, 5);
    redirect = 1'b1; redirect_pc = 16'h0090;
    tick();
    redirect = 1'b0;
    check("drop_valid", 32'(ins_valid), 0);
    check("drop_addr", 32'(mem_addr), 32'h90);

    // Reset pulse during LATCH_ARG of SIPUSH at address 1.
    redirect = 1'b1; redirect_pc = 16'h0001;
    tick();
    redirect = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_rd", 32'(mem_rd), 0);
    check("rst_mid_addr", 32'(mem_addr), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_hold_rd_valid", {mem_rd, ins_valid}, 0);
      check("rst_hold_bundle", {opcode, arg1, arg2}, 0);
      check("rst_hold_pc", {ins_pc, mem_addr}, 0);
    end

    // Randomized walk from address 0 with random back-pressure.
    predict(16'h0000, 40);
    rst = 1'b0;
    #1;
    check("post_rst_rd", 32'(mem_rd), 1);
    check("post_rst_addr", 32'(mem_addr), 0);
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
      ins_ready = 1'($urandom_range(0, 1));
      tick();
    end
    ins_ready = 1'b0;
    check("random_drained", exp_q.size(), 0);

    // PC_WIDTH=4: BIPUSH at 0xF with its argument wrapping to 0x0.
    rst4 = 1'b0; redirect4 = 1'b1; b_redirect_pc = 4'hF;
    tick();
    redirect4 = 1'b0;
    check("w4_op_addr", {b_mem_rd, b_mem_addr}, 32'h1F);
    repeat (3) tick();
    check("w4_arg_addr", {b_mem_rd, b_mem_addr}, 32'h10);
    repeat (2) tick();
    check("w4_valid", 32'(b_ins_valid), 1);
    check("w4_bundle", {b_opcode, b_arg1, b_arg2}, 32'h107700);
    check("w4_ins_pc", 32'(b_ins_pc), 32'hF);
    tick();
    check("w4_next_addr", {b_mem_rd, b_mem_addr}, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
